bist_response_checker: RTL and testbench
========================================

# bist_response_checker

BIST response-side consumer. It reads a stream of captured response words through a valid/ready handshake and folds each word into a multiple-input signature register (MISR). After a programmed number of words it compares the signature against a golden value and reports pass/fail. It sits downstream of the pattern-application datapath and its capture registers, and hands a single verdict to the BIST controller.

## Interface
- DATA_WIDTH, 32, width of response words, signature and golden value
- COUNT_WIDTH, 8, width of the word counter and of num_words
- MISR_POLY, 32'h04C11DB7, feedback polynomial (DATA_WIDTH bits)
- MISR_SEED, 32'hFFFFFFFF, signature value loaded at start (DATA_WIDTH bits)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous reset, active high
- start  in  1  begin a run; honoured only in IDLE
- num_words  in  COUNT_WIDTH  words to compact; sampled on accepted start
- golden  in  DATA_WIDTH  expected signature; sampled on accepted start
- in_valid  in  1  response word available
- in_data  in  DATA_WIDTH  response word
- in_ready  out  1  checker accepts a word this cycle
- busy  out  1  high in RUN and CHECK
- done  out  1  one-cycle pulse when the verdict is valid
- pass  out  1  signature == golden; valid from done, held until next accepted start
- signature  out  DATA_WIDTH  current MISR value
- word_count  out  COUNT_WIDTH  words accepted in the current run

## Operation
- States: IDLE, RUN, CHECK, DONE.
- IDLE: in_ready=0. When start=1:
  - latch num_words and golden
  - signature <= MISR_SEED, word_count <= 0, pass <= 0
  - go to RUN, or go directly to CHECK if num_words==0
- RUN: in_ready=1. A word is accepted when in_valid && in_ready.
  - On each accepted word: signature <= {signature[W-2:0],1'b0} ^ (signature[W-1] ? MISR_POLY : 0) ^ in_data, and word_count <= word_count+1.
  - The accept that brings word_count to num_words moves the block to CHECK.
  - With in_valid=0, no state changes.
- CHECK: in_ready=0. pass <= (signature == latched golden). Go to DONE.
- DONE: done=1 for this cycle only. Go to IDLE.
- start outside IDLE is ignored. A new start in IDLE does not need to wait for anything.
- word_count holds its final value in IDLE until the next accepted start.
- rst at any time, including mid-run:
  - state=IDLE
  - signature=0, word_count=0, pass=0, done=0, busy=0, in_ready=0
  - latched num_words and golden are cleared to 0
  - any partial run is discarded.

## Timing
- in_ready, busy and done are registered state decodes; none depend combinationally on inputs.
- Start accepted at cycle T:
  - RUN (in_ready=1) from T+1.
  - With back-to-back valid words, the last word is accepted at T+N.
  - CHECK at T+N+1.
  - done=1 at T+N+2, with pass already valid in that cycle.
  - IDLE at T+N+3.
- num_words==0: CHECK at T+1, done at T+2, signature=MISR_SEED.
- in_valid gaps stretch RUN one cycle per idle cycle. There is no timeout.
- num_words = 2^COUNT_WIDTH−1 is the maximum. word_count never wraps within a run.

## Test plan
- Reset: hold rst 2 cycles with start=1 and in_valid=1 → all outputs 0, state IDLE; start not honoured while rst=1.
- Single word: num_words=1, golden=32'hFB3EE249, in_data=32'h0 → signature=FB3EE249, done pulse at T+3, pass=1, word_count=1.
- Empty run: num_words=0, golden=32'hFFFFFFFF → no in_ready, done at T+2, pass=1; repeat with golden=0 → pass=0.
- Throttled stream: num_words=4, data 1,2,3,4 with in_valid low every other cycle → signature equals a reference model of the same 4 words as the back-to-back case, done 4 cycles later, in_ready drops right after the 4th accept.
- Mismatch and hold: 4-word run with golden off by one bit → pass=0 at done; pass and signature hold in IDLE; start during RUN of the next run is ignored.
- Reset mid-run: assert rst after 2 of 8 words → immediate IDLE, signature=0, no done pulse; a fresh 1-word run afterwards passes.

Source files
------------

// File: rtl/bist_response_checker.sv
// bist_response_checker: compacts a valid/ready stream of response words into a MISR
// and compares the final signature against a golden value latched at start.
module bist_response_checker #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    COUNT_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] MISR_POLY   = 32'h04C11DB7,
    parameter logic [DATA_WIDTH-1:0] MISR_SEED   = 32'hFFFFFFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] num_words,
    input  logic [DATA_WIDTH-1:0]  golden,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [DATA_WIDTH-1:0]  signature,
    output logic [COUNT_WIDTH-1:0] word_count
);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  sig_q, sig_d, gold_q, gold_d, misr_next;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, num_q, num_d, cnt_inc;
    logic                   pass_q, pass_d, accept;

    assign accept    = (state_q == RUN) && in_valid;
    assign cnt_inc   = cnt_q + COUNT_WIDTH'(1);
    assign misr_next = {sig_q[DATA_WIDTH-2:0], 1'b0} ^ (sig_q[DATA_WIDTH-1] ? MISR_POLY : '0) ^ in_data;

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        gold_d  = gold_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d   = num_words;
                    gold_d  = golden;
                    sig_d   = MISR_SEED;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    state_d = (num_words == '0) ? CHECK : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    sig_d   = misr_next;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == num_q) ? CHECK : RUN;
                end
            end
            CHECK: begin
                pass_d  = (sig_q == gold_q);
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sig_q   <= '0;
            gold_q  <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            gold_q  <= gold_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            pass_q  <= pass_d;
        end
    end

    assign in_ready   = (state_q == RUN);
    assign busy       = (state_q == RUN) || (state_q == CHECK);
    assign done       = (state_q == DONE);
    assign pass       = pass_q;
    assign signature  = sig_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_bist_response_checker.sv
// tb_bist_response_checker: directed runs against a transaction-level model of the
// checker (accepted-word queue folded from the seed), compared every cycle.
module tb_bist_response_checker;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  num_words;
    logic [31:0] golden, in_data;
    logic        in_ready, busy, done, pass;
    logic [31:0] signature;
    logic [7:0]  word_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    logic [31:0] d_arr [256];

    bist_response_checker dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words), .golden(golden),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
        .done(done), .pass(pass), .signature(signature), .word_count(word_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mstep(input logic [31:0] s, input logic [31:0] d);
        return (s << 1) ^ (s[31] ? POLY : 32'h0) ^ d;
    endfunction

    function automatic logic [31:0] exp_sig(input int n);
        logic [31:0] s = SEED;
        for (int i = 0; i < n; i++) s = mstep(s, d_arr[i]);
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: phase 0 idle, 1 collecting words, 2 checking, 3 verdict cycle
    int          m_phase = 0;
    bit          m_valid = 0, m_cleared = 1, m_pass = 0;
    logic [31:0] m_words [$];
    int          m_num = 0;
    logic [31:0] m_gold = 0;

    function automatic logic [31:0] model_sig();
        logic [31:0] s = SEED;
        if (m_cleared) return 32'h0;
        foreach (m_words[i]) s = mstep(s, m_words[i]);
        return s;
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_valid = 1; m_phase = 0; m_words.delete(); m_num = 0; m_gold = 0;
            m_pass = 0; m_cleared = 1;
        end else if (m_phase == 0) begin
            if (start) begin
                m_num = int'(num_words); m_gold = golden; m_words.delete();
                m_pass = 0; m_cleared = 0; m_phase = (m_num == 0) ? 2 : 1;
            end
        end else if (m_phase == 1) begin
            if (in_valid) begin
                m_words.push_back(in_data);
                if (m_words.size() == m_num) m_phase = 2;
            end
        end else if (m_phase == 2) begin
            m_pass = (model_sig() == m_gold); m_phase = 3;
        end else m_phase = 0;
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("in_ready", 32'(in_ready), 32'(m_phase == 1));
            chk("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
            chk("done", 32'(done), 32'(m_phase == 3));
            chk("pass", 32'(pass), 32'(m_pass));
            chk("signature", signature, model_sig());
            chk("word_count", 32'(word_count), m_cleared ? 32'h0 : 32'(m_words.size()));
        end
    end

    task automatic do_start(input int n, input logic [31:0] g);
        start = 1; num_words = 8'(n); golden = g; t0 = cyc;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic feed(input int n, input bit gaps);
        int k = 0, c = 0;
        bit tog = 0, acc;
        while (k < n && c < 600) begin
            in_valid = gaps ? tog : 1'b1; in_data = d_arr[k]; tog = !tog;
            @(negedge clk); acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) k++;
            c++;
        end
        in_valid = 0;
        if (k < n) chk("feed_timeout", 32'(k), 32'(n));
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done) begin lat = cyc - t0; break; end
        end
    endtask

    initial begin
        int lat, ndone;
        rst = 1; start = 1; in_valid = 1; in_data = '1; num_words = 8'd5; golden = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_busy", 32'(busy), 0); chk("rst_ready", 32'(in_ready), 0);
        chk("rst_done", 32'(done), 0); chk("rst_pass", 32'(pass), 0);
        chk("rst_sig", signature, 0); chk("rst_wc", 32'(word_count), 0);
        rst = 0; start = 0; in_valid = 0;
        @(posedge clk); #1;

        d_arr[0] = 32'h0;
        do_start(1, 32'hFB3EE249); feed(1, 0); wait_done(lat);
        chk("single_lat", 32'(lat), 3); chk("single_sig", signature, 32'hFB3EE249);
        chk("single_pass", 32'(pass), 1); chk("single_wc", 32'(word_count), 1);
        @(posedge clk); #1;

        do_start(0, 32'hFFFFFFFF); wait_done(lat);
        chk("empty_lat", 32'(lat), 2); chk("empty_pass", 32'(pass), 1);
        chk("empty_sig", signature, 32'hFFFFFFFF);
        @(posedge clk); #1;
        do_start(0, 32'h0); wait_done(lat);
        chk("empty0_lat", 32'(lat), 2); chk("empty0_pass", 32'(pass), 0);
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) d_arr[i] = 32'(i + 1);
        do_start(4, exp_sig(4)); feed(4, 0); wait_done(lat);
        chk("b2b_lat", 32'(lat), 6); chk("b2b_pass", 32'(pass), 1);
        @(posedge clk); #1;
        do_start(4, exp_sig(4)); feed(4, 1); wait_done(lat);
        chk("thr_lat", 32'(lat), 10); chk("thr_pass", 32'(pass), 1);
        chk("thr_sig", signature, exp_sig(4));
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) d_arr[i] = 32'hA5A50000 + 32'(i);
        do_start(4, exp_sig(4) ^ 32'h1); feed(4, 0); wait_done(lat);
        chk("mis_pass", 32'(pass), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("hold_pass", 32'(pass), 0); chk("hold_sig", signature, exp_sig(4));
        chk("hold_wc", 32'(word_count), 4);
        @(posedge clk); #1;
        do_start(2, exp_sig(2));
        start = 1; num_words = 8'd0; golden = 32'h0;
        feed(2, 0);
        start = 0;
        wait_done(lat);
        chk("ign_lat", 32'(lat), 4); chk("ign_pass", 32'(pass), 1);
        chk("ign_wc", 32'(word_count), 2);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) d_arr[i] = 32'h1000 + 32'(i);
        do_start(8, 32'h0); feed(2, 0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("mrst_sig", signature, 0); chk("mrst_busy", 32'(busy), 0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (done) ndone++; end
        chk("mrst_nodone", 32'(ndone), 0);
        @(posedge clk); #1;
        d_arr[0] = 32'h0;
        do_start(1, 32'hFB3EE249); feed(1, 0); wait_done(lat);
        chk("fresh_lat", 32'(lat), 3); chk("fresh_pass", 32'(pass), 1);
        @(posedge clk); #1;

        for (int i = 0; i < 256; i++) d_arr[i] = 32'(i * 3 + 1);
        do_start(255, exp_sig(255)); feed(255, 0); wait_done(lat);
        chk("max_lat", 32'(lat), 257); chk("max_wc", 32'(word_count), 255);
        chk("max_pass", 32'(pass), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
